// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: sub-word load extraction plus a two-entry (main + skid)
// elastic buffer with registered handshake, flush and zero-register write suppression.
module mem_wb_pipe #(
    parameter int unsigned DATA_W            = 32,
    parameter int unsigned REG_W             = 5,
    parameter int unsigned ZERO_REG_SUPPRESS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] read_data,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [REG_W-1:0]  rd_num,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  rd_num_out,
    output logic              reg_write_out,
    output logic [1:0]        occupancy
);

    localparam int unsigned EXT_B = DATA_W - 8;
    localparam int unsigned EXT_H = DATA_W - 16;

    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [REG_W-1:0]  main_rd, skid_rd;
    logic              main_rwq, skid_rwq;
    logic              in_ready_q, rwo_q;
    logic [1:0]        occ_q;

    logic              main_v_n, skid_v_n;
    logic [DATA_W-1:0] main_data_n, skid_data_n;
    logic [REG_W-1:0]  main_rd_n, skid_rd_n;
    logic              main_rwq_n, skid_rwq_n;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_val;
    logic [DATA_W-1:0] in_data;
    logic              in_rwq;
    logic              accept, present;

    // Extract and extend the addressed load lane before it is captured.
    always_comb begin
        ld_byte = read_data[7:0];
        case (alu_result[1:0])
            2'd0:    ld_byte = read_data[7:0];
            2'd1:    ld_byte = read_data[15:8];
            2'd2:    ld_byte = read_data[23:16];
            default: ld_byte = read_data[31:24];
        endcase
        ld_half = alu_result[1] ? read_data[31:16] : read_data[15:0];
        case (load_size)
            2'b00:   ld_val = load_unsigned ? {{EXT_B{1'b0}}, ld_byte}
                                            : {{EXT_B{ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = load_unsigned ? {{EXT_H{1'b0}}, ld_half}
                                            : {{EXT_H{ld_half[15]}}, ld_half};
            default: ld_val = DATA_W'(read_data[31:0]);
        endcase
        in_data = mem_to_reg ? ld_val : alu_result;
        in_rwq  = reg_write && !((ZERO_REG_SUPPRESS != 0) && (rd_num == '0));
    end

    // Next-state of the main/skid entries from the accept/present handshakes.
    always_comb begin
        main_v_n    = main_v;
        main_data_n = main_data;
        main_rd_n   = main_rd;
        main_rwq_n  = main_rwq;
        skid_v_n    = skid_v;
        skid_data_n = skid_data;
        skid_rd_n   = skid_rd;
        skid_rwq_n  = skid_rwq;
        accept      = in_valid && in_ready_q;
        present     = main_v && out_ready;
        if (flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (present && skid_v) begin
            // in_ready is low whenever skid is full, so no accept can collide here
            main_data_n = skid_data;
            main_rd_n   = skid_rd;
            main_rwq_n  = skid_rwq;
            skid_v_n    = 1'b0;
        end else if (accept && (!main_v || present)) begin
            main_v_n    = 1'b1;
            main_data_n = in_data;
            main_rd_n   = rd_num;
            main_rwq_n  = in_rwq;
        end else if (accept) begin
            skid_v_n    = 1'b1;
            skid_data_n = in_data;
            skid_rd_n   = rd_num;
            skid_rwq_n  = in_rwq;
        end else if (present) begin
            main_v_n = 1'b0;
        end
    end

    // Entry storage and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v     <= 1'b0;
            main_data  <= '0;
            main_rd    <= '0;
            main_rwq   <= 1'b0;
            skid_v     <= 1'b0;
            skid_data  <= '0;
            skid_rd    <= '0;
            skid_rwq   <= 1'b0;
            in_ready_q <= 1'b0;
            rwo_q      <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            main_v     <= main_v_n;
            main_data  <= main_data_n;
            main_rd    <= main_rd_n;
            main_rwq   <= main_rwq_n;
            skid_v     <= skid_v_n;
            skid_data  <= skid_data_n;
            skid_rd    <= skid_rd_n;
            skid_rwq   <= skid_rwq_n;
            in_ready_q <= !skid_v_n;
            rwo_q      <= main_v_n && main_rwq_n;
            occ_q      <= 2'(main_v_n) + 2'(skid_v_n);
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_v;
    assign wb_data       = main_data;
    assign rd_num_out    = main_rd;
    assign reg_write_out = rwo_q;
    assign occupancy     = occ_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: queue model of held beats checked every cycle, plus literal pins.
module tb_mem_wb_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        rw;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] alu_result, read_data;
    logic        mem_to_reg, reg_write;
    logic [4:0]  rd_num;
    logic [1:0]  load_size;
    logic        load_unsigned, flush;
    logic        out_valid, out_ready;
    logic [31:0] wb_data;
    logic [4:0]  rd_num_out;
    logic        reg_write_out;
    logic [1:0]  occupancy;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    beat_t q[$];
    logic  m_ready;

    mem_wb_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .read_data(read_data),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .rd_num(rd_num),
        .load_size(load_size), .load_unsigned(load_unsigned), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .rd_num_out(rd_num_out),
        .reg_write_out(reg_write_out), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Value the register file should receive for a beat, from the load rules.
    function automatic logic [31:0] wb_value(input logic [31:0] alu, input logic [31:0] rdat,
                                             input logic m2r, input logic [1:0] ls, input logic lu);
        logic [31:0] v;
        if (!m2r) return alu;
        case (ls)
            2'b00: begin
                v = (rdat >> (8 * alu[1:0])) & 32'h0000_00FF;
                if (!lu && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (rdat >> (16 * alu[1])) & 32'h0000_FFFF;
                if (!lu && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = rdat;
        endcase
        return v;
    endfunction

    // Model: an ordered list of held beats, at most two, with a one-cycle-late ready.
    always @(posedge clk or posedge rst) begin
        beat_t b;
        logic  acc;
        if (rst) begin
            q.delete();
            m_ready = 1'b0;
        end else begin
            if (flush) begin
                q.delete();
            end else begin
                acc = in_valid && m_ready;
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (acc) begin
                    b.d  = wb_value(alu_result, read_data, mem_to_reg, load_size, load_unsigned);
                    b.rd = rd_num;
                    b.rw = reg_write;
                    q.push_back(b);
                end
            end
            m_ready = (q.size() < 2);
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("m_occupancy", 32'(occupancy), 32'(q.size()));
            chk("m_in_ready", 32'(in_ready), 32'(m_ready));
            if (q.size() > 0) begin
                chk("m_wb_data", wb_data, q[0].d);
                chk("m_rd_num_out", 32'(rd_num_out), 32'(q[0].rd));
                chk("m_reg_write_out", 32'(reg_write_out), 32'(q[0].rw && (q[0].rd != 5'd0)));
            end else begin
                chk("m_reg_write_out_idle", 32'(reg_write_out), 32'd0);
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic m2r, input logic rw, input logic [4:0] rd,
                         input logic [1:0] ls, input logic lu, input logic fl, input logic ordy);
        in_valid      = v;
        alu_result    = alu;
        read_data     = rdat;
        mem_to_reg    = m2r;
        reg_write     = rw;
        rd_num        = rd;
        load_size     = ls;
        load_unsigned = lu;
        flush         = fl;
        out_ready     = ordy;
        @(negedge clk);
    endtask

    task automatic alu_beat(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                            input logic fl, input logic ordy);
        drive(v, alu, 32'h0, 1'b0, 1'b1, rd, 2'b10, 1'b0, fl, ordy);
    endtask

    task automatic ld_beat(input logic [31:0] alu, input logic [1:0] ls, input logic lu);
        drive(1'b1, alu, 32'h80FF_7F01, 1'b1, 1'b1, 5'd4, ls, lu, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h55, 32'h0, 1'b0, 1'b1, 5'd3, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_reg_write_out", 32'(reg_write_out), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_rd_num_out", 32'(rd_num_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);

        rst    = 1'b0;
        chk_en = 1'b1;
        alu_beat(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        chk("rst_release_in_ready", 32'(in_ready), 32'd1);

        // Streaming ALU beats, one per cycle.
        for (int i = 0; i < 4; i++) begin
            alu_beat(1'b1, 32'h1000 + 32'(i), 5'(i + 1), 1'b0, 1'b1);
            chk("stream_wb_data", wb_data, 32'h1000 + 32'(i));
            chk("stream_occupancy", 32'(occupancy), 32'd1);
        end
        alu_beat(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure: two accepted, third refused until space frees up.
        alu_beat(1'b1, 32'h2000, 5'd7, 1'b0, 1'b0);
        alu_beat(1'b1, 32'h2001, 5'd8, 1'b0, 1'b0);
        chk("stall_occupancy", 32'(occupancy), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        alu_beat(1'b1, 32'h2002, 5'd9, 1'b0, 1'b0);
        chk("stall_hold_data", wb_data, 32'h2000);
        chk("stall_hold_occ", 32'(occupancy), 32'd2);
        alu_beat(1'b1, 32'h2002, 5'd9, 1'b0, 1'b1);
        chk("release_second", wb_data, 32'h2001);
        alu_beat(1'b1, 32'h2002, 5'd9, 1'b0, 1'b1);
        chk("release_third", wb_data, 32'h2002);
        chk("release_rd", 32'(rd_num_out), 32'd9);
        alu_beat(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

        // Load extraction against a fixed memory word.
        ld_beat(32'h0000_0101, 2'b00, 1'b0);
        chk("ld_byte1_s", wb_data, 32'h0000_007F);
        ld_beat(32'h0000_0103, 2'b00, 1'b0);
        chk("ld_byte3_s", wb_data, 32'hFFFF_FF80);
        ld_beat(32'h0000_0102, 2'b01, 1'b1);
        chk("ld_half1_u", wb_data, 32'h0000_80FF);
        ld_beat(32'h0000_0102, 2'b01, 1'b0);
        chk("ld_half1_s", wb_data, 32'hFFFF_80FF);
        ld_beat(32'h0000_0100, 2'b10, 1'b0);
        chk("ld_word", wb_data, 32'h80FF_7F01);
        ld_beat(32'h0000_0100, 2'b00, 1'b1);
        chk("ld_byte0_u", wb_data, 32'h0000_0001);
        ld_beat(32'h0000_0102, 2'b11, 1'b1);
        chk("ld_word11", wb_data, 32'h80FF_7F01);

        // Zero-register suppression.
        alu_beat(1'b1, 32'hAAAA, 5'd0, 1'b0, 1'b1);
        chk("zr_rd0", 32'(reg_write_out), 32'd0);
        alu_beat(1'b1, 32'hBBBB, 5'd5, 1'b0, 1'b1);
        chk("zr_rd5_we", 32'(reg_write_out), 32'd1);
        chk("zr_rd5_num", 32'(rd_num_out), 32'd5);
        drive(1'b1, 32'hCCCC, 32'h0, 1'b0, 1'b0, 5'd6, 2'b10, 1'b0, 1'b0, 1'b1);
        chk("zr_no_write", 32'(reg_write_out), 32'd0);
        alu_beat(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

        // Flush with both entries full and a beat offered.
        alu_beat(1'b1, 32'h3000, 5'd3, 1'b0, 1'b0);
        alu_beat(1'b1, 32'h3001, 5'd3, 1'b0, 1'b0);
        chk("pre_flush_occ", 32'(occupancy), 32'd2);
        alu_beat(1'b1, 32'h3002, 5'd3, 1'b1, 1'b0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_occupancy", 32'(occupancy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        alu_beat(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        chk("flush_nothing_emerges", 32'(out_valid), 32'd0);
        // Flush while ready: the offered beat is dropped too.
        alu_beat(1'b1, 32'h3003, 5'd3, 1'b1, 1'b1);
        chk("flush_ready_drop", 32'(occupancy), 32'd0);
        alu_beat(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

        // Asynchronous reset between edges with both entries full.
        alu_beat(1'b1, 32'h4000, 5'd2, 1'b0, 1'b0);
        alu_beat(1'b1, 32'h4001, 5'd2, 1'b0, 1'b0);
        chk("pre_rst_occ", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_occupancy", 32'(occupancy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_release_wait", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("arst_release_ready", 32'(in_ready), 32'd1);
        alu_beat(1'b1, 32'h5000, 5'd1, 1'b0, 1'b1);
        chk("post_rst_beat", wb_data, 32'h5000);
        alu_beat(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter DATA_W, default 32, sets the datapath width; it SHALL be a multiple of 8 and at least 32.
REQ-002 Parameter REG_W, default 5, sets the destination register number width.
REQ-003 Parameter ZERO_REG_SUPPRESS, default 1; when set, a write to register 0 is forced to reg_write_out=0.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1: the upstream MEM beat is valid.
REQ-007 Port in_ready, output, 1: the block can accept a beat this cycle.
REQ-008 Port alu_result, input, DATA_W: ALU result or memory address.
REQ-009 Port read_data, input, DATA_W: raw memory word.
REQ-010 Port mem_to_reg, input, 1: selects the load path (1) or the ALU path (0).
REQ-011 Port reg_write, input, 1: the beat writes the register file.
REQ-012 Port rd_num, input, REG_W: destination register.
REQ-013 Port load_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = word.
REQ-014 Port load_unsigned, input, 1: zero-extend (1) or sign-extend (0) sub-word loads.
REQ-015 Port flush, input, 1: synchronous kill of all held beats.
REQ-016 Port out_valid, output, 1: a writeback beat is presented.
REQ-017 Port out_ready, input, 1: downstream accepts the presented beat.
REQ-018 Port wb_data, output, DATA_W: final writeback value.
REQ-019 Port rd_num_out, output, REG_W: destination of the presented beat.
REQ-020 Port reg_write_out, output, 1: qualified write enable.
REQ-021 Port occupancy, output, 2: number of held beats, 0 to 2.

Function
REQ-022 Storage SHALL be two entries, main and skid; out_* fields SHALL come from main.
REQ-023 in_ready SHALL be a registered value equal to 1 exactly when skid is empty.
REQ-024 Accept SHALL occur when in_valid && in_ready; present SHALL occur when out_valid && out_ready.
REQ-025 Accept with main empty, or main being presented the same cycle, SHALL load main; otherwise it SHALL load skid.
REQ-026 Present with skid full SHALL move skid to main the next cycle; a simultaneous accept is impossible because in_ready=0.
REQ-027 Input-to-output latency SHALL be 1 cycle with no stall; sustained throughput SHALL be 1 beat per cycle when out_ready=1.
REQ-028 Held entries SHALL be unchanged while out_ready=0, and no beat SHALL be dropped or duplicated.
REQ-029 Load extraction SHALL be computed before capture; byte offset = alu_result[1:0], half offset = alu_result[1].
REQ-030 A byte load SHALL select read_data[8*off+7:8*off]; a half load SHALL select read_data[16*off+15:16*off].
REQ-031 Sub-word results SHALL be zero- or sign-extended to DATA_W according to load_unsigned.
REQ-032 A word load SHALL select read_data[31:0], zero-extended above bit 31 when DATA_W>32.
REQ-033 The stored writeback value SHALL be the extracted load when mem_to_reg=1, else alu_result.
REQ-034 reg_write_out SHALL equal out_valid && stored reg_write && !(ZERO_REG_SUPPRESS && rd_num_out==0).
REQ-035 flush SHALL clear both entries' valid bits on the next edge, regardless of other inputs.
REQ-036 A beat offered in the same cycle as flush SHALL be dropped.
REQ-037 in_ready SHALL return to 1 in the cycle after a flush.
REQ-038 occupancy SHALL equal the count of valid entries, registered.

Reset
REQ-039 While rst=1, out_valid, reg_write_out, occupancy, wb_data and rd_num_out SHALL be 0 and in_ready SHALL be 0.
REQ-040 in_ready SHALL rise to 1 on the first clock edge after rst deasserts.
REQ-041 Reset asserted mid-operation SHALL discard held beats immediately, without waiting for a clock edge.

Verification
REQ-042 Stream 4 ALU beats with out_ready=1 -> outputs follow 1 cycle later, back-to-back, in order, occupancy stays 1.
REQ-043 Hold out_ready=0 with 3 beats offered -> 2 accepted, in_ready=0 on the third, occupancy=2; then release out_ready -> beats emerge in order, none lost.
REQ-044 Load tests with read_data=0x80FF7F01: byte at offset 1, signed -> 0x0000007F; byte at offset 3, signed -> 0xFFFFFF80; half at offset 1, unsigned -> 0x000080FF; word -> 0x80FF7F01.
REQ-045 reg_write=1 with rd_num=0 -> reg_write_out=0; with rd_num=5 -> reg_write_out=1 and rd_num_out=5.
REQ-046 flush asserted with occupancy=2 and in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, and the offered beat never appears.
REQ-047 Assert rst between clock edges with occupancy=2 -> out_valid=0 at once; after deassert, in_ready=1 on the next edge.
